// File: rtl/mem_cmd_status_mux.sv
// mem_cmd_status_mux
// Round-robin N:1 merge of memory command streams onto one memory-side port.
// Every granted command records its source channel in a small in-order
// tracking FIFO; returning status words are steered back to the recorded
// channel strictly in the order the commands were issued.

module mem_cmd_status_mux #(
    parameter int NUM_CHANNELS    = 2,
    parameter int MAX_OUTSTANDING = 16,
    parameter int IDX_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         aclk,
    input  logic                         aresetn,

    input  logic [NUM_CHANNELS-1:0]      s_cmd_valid,
    output logic [NUM_CHANNELS-1:0]      s_cmd_ready,
    input  logic [NUM_CHANNELS*64-1:0]   s_cmd_address,
    input  logic [NUM_CHANNELS*32-1:0]   s_cmd_length,

    output logic                         m_cmd_valid,
    input  logic                         m_cmd_ready,
    output logic [63:0]                  m_cmd_address,
    output logic [31:0]                  m_cmd_length,
    output logic [IDX_W-1:0]             m_cmd_dest,

    input  logic                         s_sts_valid,
    output logic                         s_sts_ready,
    input  logic [7:0]                   s_sts_data,

    output logic [NUM_CHANNELS-1:0]      m_sts_valid,
    input  logic [NUM_CHANNELS-1:0]      m_sts_ready,
    output logic [NUM_CHANNELS*8-1:0]    m_sts_data,

    output logic [CNT_W-1:0]             outstanding
);

    localparam int                PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W:0]    NUM_CH_W = (IDX_W + 1)'(NUM_CHANNELS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   run_q,           run_d;
    logic                   m_cmd_valid_q,   m_cmd_valid_d;
    logic [63:0]            m_cmd_address_q, m_cmd_address_d;
    logic [31:0]            m_cmd_length_q,  m_cmd_length_d;
    logic [IDX_W-1:0]       m_cmd_dest_q,    m_cmd_dest_d;
    logic [IDX_W-1:0]       rr_ptr_q,        rr_ptr_d;
    logic [CNT_W-1:0]       count_q,         count_d;
    logic [PTR_W-1:0]       wr_ptr_q,        wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,        rd_ptr_d;
    logic [IDX_W-1:0]       fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0]       fifo_d [MAX_OUTSTANDING];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                   slot_free_s;
    logic                   arb_en_s;
    logic                   grant_found_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W:0]         cand_sum_s;
    logic [IDX_W-1:0]       cand_idx_s;
    logic                   cand_hit_s;
    logic [63:0]            sel_address_s;
    logic [31:0]            sel_length_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   empty_s;
    logic [IDX_W-1:0]       head_s;

    // Output slot can take a new command when empty or being drained this cycle.
    always_comb begin
        slot_free_s = !m_cmd_valid_q || m_cmd_ready;
        // A full tracker blocks pushes regardless of any pop in the same cycle,
        // so nothing on the status side reaches s_cmd_ready.
        arb_en_s    = run_q && slot_free_s && (count_q != CNT_FULL);
    end

    // Round-robin search: first valid channel starting at rr_ptr_q, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_idx_s    = '0;
        cand_hit_s    = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            cand_sum_s    = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            cand_sum_s    = (cand_sum_s >= NUM_CH_W) ? (cand_sum_s - NUM_CH_W) : cand_sum_s;
            cand_idx_s    = cand_sum_s[IDX_W-1:0];
            cand_hit_s    = !grant_found_s && s_cmd_valid[cand_idx_s];
            grant_idx_s   = cand_hit_s ? cand_idx_s : grant_idx_s;
            grant_found_s = grant_found_s || cand_hit_s;
        end
    end

    // Payload mux for the granted channel.
    always_comb begin
        sel_address_s = 64'h0;
        sel_length_s  = 32'h0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sel_address_s = (grant_idx_s == IDX_W'(i)) ? s_cmd_address[i*64 +: 64] : sel_address_s;
            sel_length_s  = (grant_idx_s == IDX_W'(i)) ? s_cmd_length[i*32 +: 32]  : sel_length_s;
        end
    end

    // Handshake qualifiers and per-channel ready.
    always_comb begin
        push_s = arb_en_s && grant_found_s;
        if (push_s) begin
            s_cmd_ready = NUM_CHANNELS'(1) << grant_idx_s;
        end else begin
            s_cmd_ready = '0;
        end
    end

    // Status steering: head of the tracker selects the destination channel.
    always_comb begin
        empty_s     = (count_q == '0);
        head_s      = fifo_q[rd_ptr_q];
        s_sts_ready = !empty_s && m_sts_ready[head_s];
        pop_s       = s_sts_valid && s_sts_ready;
        if (s_sts_valid && !empty_s) begin
            m_sts_valid = NUM_CHANNELS'(1) << head_s;
        end else begin
            m_sts_valid = '0;
        end
    end

    assign m_sts_data = {NUM_CHANNELS{s_sts_data}};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Reset-release qualifier: keeps s_cmd_ready low until the first clock after reset.
    always_comb begin
        run_d = 1'b1;
    end

    // Command output register: load on grant, clear on drain, otherwise hold.
    always_comb begin
        m_cmd_valid_d   = m_cmd_valid_q;
        m_cmd_address_d = m_cmd_address_q;
        m_cmd_length_d  = m_cmd_length_q;
        m_cmd_dest_d    = m_cmd_dest_q;
        if (push_s) begin
            m_cmd_valid_d   = 1'b1;
            m_cmd_address_d = sel_address_s;
            m_cmd_length_d  = sel_length_s;
            m_cmd_dest_d    = grant_idx_s;
        end else if (m_cmd_valid_q && m_cmd_ready) begin
            m_cmd_valid_d   = 1'b0;
        end else begin
            m_cmd_valid_d   = m_cmd_valid_q;
        end
    end

    // Round-robin pointer moves to the channel after the last grant.
    always_comb begin
        if (push_s) begin
            rr_ptr_d = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + IDX_W'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Tracker storage and pointers; pointers wrap naturally at MAX_OUTSTANDING.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = grant_idx_s;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d         = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control and command-output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_q           <= 1'b0;
            m_cmd_valid_q   <= 1'b0;
            m_cmd_address_q <= 64'h0;
            m_cmd_length_q  <= 32'h0;
            m_cmd_dest_q    <= '0;
            rr_ptr_q        <= '0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            run_q           <= run_d;
            m_cmd_valid_q   <= m_cmd_valid_d;
            m_cmd_address_q <= m_cmd_address_d;
            m_cmd_length_q  <= m_cmd_length_d;
            m_cmd_dest_q    <= m_cmd_dest_d;
            rr_ptr_q        <= rr_ptr_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
        end
    end

    // Grant-order tracker entries; cleared on reset so stale records never leak.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign m_cmd_valid   = m_cmd_valid_q;
    assign m_cmd_address = m_cmd_address_q;
    assign m_cmd_length  = m_cmd_length_q;
    assign m_cmd_dest    = m_cmd_dest_q;
    assign outstanding   = count_q;

endmodule

// File: tb/tb_mem_cmd_status_mux.sv
// Scoreboard bench for mem_cmd_status_mux (2 channels, 4-deep tracker).
// Stimulus pushes hand-computed expectations into queues; two monitors pop
// and compare on every command / status handshake.

module tb_mem_cmd_status_mux;

    localparam int N  = 2;
    localparam int MO = 4;
    localparam int IW = 1;
    localparam int CW = 3;

    logic               aclk;
    logic               aresetn;
    logic [N-1:0]       s_cmd_valid;
    logic [N-1:0]       s_cmd_ready;
    logic [N*64-1:0]    s_cmd_address;
    logic [N*32-1:0]    s_cmd_length;
    logic               m_cmd_valid;
    logic               m_cmd_ready;
    logic [63:0]        m_cmd_address;
    logic [31:0]        m_cmd_length;
    logic [IW-1:0]      m_cmd_dest;
    logic               s_sts_valid;
    logic               s_sts_ready;
    logic [7:0]         s_sts_data;
    logic [N-1:0]       m_sts_valid;
    logic [N-1:0]       m_sts_ready;
    logic [N*8-1:0]     m_sts_data;
    logic [CW-1:0]      outstanding;

    mem_cmd_status_mux #(.NUM_CHANNELS(N), .MAX_OUTSTANDING(MO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
        .m_cmd_dest(m_cmd_dest),
        .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
        .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
        .outstanding(outstanding)
    );

    typedef struct packed {
        logic [IW-1:0] dest;
        logic [63:0]   addr;
        logic [31:0]   len;
    } cmd_t;

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] data;
    } sts_t;

    cmd_t exp_cmd_q[$];
    sts_t exp_sts_q[$];
    cmd_t mon_cmd_e;
    sts_t mon_sts_e;
    logic [N-1:0] mon_hs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] atab [2][3];
    logic [31:0] ltab [2][3];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Command-side monitor.
    always @(negedge aclk) begin
        if (aresetn && m_cmd_valid && m_cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'(m_cmd_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_cmd_e = exp_cmd_q.pop_front();
                check("cmd_dest", 64'(m_cmd_dest),    64'(mon_cmd_e.dest));
                check("cmd_addr", m_cmd_address,      mon_cmd_e.addr);
                check("cmd_len",  64'(m_cmd_length),  64'(mon_cmd_e.len));
            end
        end
    end

    // Status-side monitor.
    always @(negedge aclk) begin
        mon_hs = m_sts_valid & m_sts_ready;
        if (aresetn && (mon_hs != '0)) begin
            if (exp_sts_q.size() == 0) begin
                check("sts_unexpected", 64'(mon_hs), 64'd0);
            end else begin
                mon_sts_e = exp_sts_q.pop_front();
                check("sts_route", 64'(mon_hs), 64'(N'(1) << mon_sts_e.ch));
                check("sts_data",  64'(m_sts_data[mon_sts_e.ch*8 +: 8]), 64'(mon_sts_e.data));
                check("sts_ready", 64'(s_sts_ready), 64'd1);
            end
        end
    end

    // Issue one command from a single channel and wait for its grant.
    task automatic issue_cmd(input int ch, input logic [63:0] addr, input logic [31:0] len);
        int cyc;
        exp_cmd_q.push_back('{dest: IW'(ch), addr: addr, len: len});
        s_cmd_valid = N'(1) << ch;
        s_cmd_address[ch*64 +: 64] = addr;
        s_cmd_length[ch*32 +: 32]  = len;
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (s_cmd_ready == '0 && cyc < 10);
        check("issue_ready", 64'(s_cmd_ready), 64'(N'(1) << ch));
        step();
        s_cmd_valid = '0;
    endtask

    // Present one status word and wait for it to be accepted.
    task automatic send_sts(input logic [7:0] data, input int exp_ch);
        int cyc;
        exp_sts_q.push_back('{ch: 8'(exp_ch), data: data});
        s_sts_valid = 1'b1;
        s_sts_data  = data;
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!s_sts_ready && cyc < 10);
        check("sts_accept", 64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int acc [2];
        int got, cyc, first_at;
        logic [N-1:0] r;

        atab[0][0] = 64'h0000_0000_0000_1000; ltab[0][0] = 32'h0000_0010;
        atab[0][1] = 64'h0000_0000_0000_2000; ltab[0][1] = 32'h0000_0000;
        atab[0][2] = 64'h0000_0000_0000_3000; ltab[0][2] = 32'h0000_0030;
        atab[1][0] = 64'hFFFF_0000_0000_0100; ltab[1][0] = 32'hFFFF_FFFF;
        atab[1][1] = 64'hFFFF_0000_0000_0200; ltab[1][1] = 32'h0000_0020;
        atab[1][2] = 64'h0;                   ltab[1][2] = 32'h0;

        aresetn       = 1'b0;
        s_cmd_valid   = 2'b11;
        s_cmd_address = '0;
        s_cmd_length  = '0;
        m_cmd_ready   = 1'b1;
        s_sts_valid   = 1'b1;
        s_sts_data    = 8'h00;
        m_sts_ready   = 2'b11;

        // Reset values, with inputs active.
        repeat (3) @(negedge aclk);
        check("rst_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        check("rst_m_cmd_addr",  m_cmd_address,    64'd0);
        check("rst_m_cmd_len",   64'(m_cmd_length), 64'd0);
        check("rst_m_cmd_dest",  64'(m_cmd_dest),  64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_s_cmd_ready", 64'(s_cmd_ready), 64'd0);
        check("rst_s_sts_ready", 64'(s_sts_ready), 64'd0);
        check("rst_m_sts_valid", 64'(m_sts_valid), 64'd0);

        // Alternating grants with both channels valid; ch0 second grant is zero-length.
        step();
        s_sts_valid = 1'b0;
        s_cmd_valid = 2'b00;
        aresetn     = 1'b1;
        exp_cmd_q.push_back('{dest: 1'b0, addr: atab[0][0], len: ltab[0][0]});
        exp_cmd_q.push_back('{dest: 1'b1, addr: atab[1][0], len: ltab[1][0]});
        exp_cmd_q.push_back('{dest: 1'b0, addr: atab[0][1], len: ltab[0][1]});
        exp_cmd_q.push_back('{dest: 1'b1, addr: atab[1][1], len: ltab[1][1]});
        acc[0] = 0; acc[1] = 0;
        s_cmd_address[0 +: 64]  = atab[0][0]; s_cmd_length[0 +: 32]  = ltab[0][0];
        s_cmd_address[64 +: 64] = atab[1][0]; s_cmd_length[32 +: 32] = ltab[1][0];
        s_cmd_valid = 2'b11;
        got = 0; cyc = 0; first_at = -1;
        while (got < 4 && cyc < 30) begin
            @(negedge aclk);
            cyc++;
            if (first_at >= 0 && cyc == first_at + 1) begin
                check("first_lat_valid", 64'(m_cmd_valid), 64'd1);
                check("first_lat_dest",  64'(m_cmd_dest),  64'd0);
            end
            r = s_cmd_ready;
            if (r != '0 && first_at < 0) begin
                first_at = cyc;
                check("first_pre_valid", 64'(m_cmd_valid), 64'd0);
            end
            step();
            for (int ch = 0; ch < N; ch++) begin
                if (r[ch]) begin
                    acc[ch]++;
                    got++;
                    if (ch == 1 && acc[1] == 2) begin
                        s_cmd_valid[1] = 1'b0;
                    end else begin
                        s_cmd_address[ch*64 +: 64] = atab[ch][acc[ch]];
                        s_cmd_length[ch*32 +: 32]  = ltab[ch][acc[ch]];
                    end
                end
            end
        end
        check("alt_grant_count", 64'(got), 64'd4);

        // Tracker full: ch0 still pending but blocked.
        @(negedge aclk);
        check("full_outstanding", 64'(outstanding), 64'd4);
        check("full_s_cmd_ready", 64'(s_cmd_ready), 64'd0);
        @(negedge aclk);
        check("full_m_cmd_valid", 64'(m_cmd_valid), 64'd0);
        step();
        exp_sts_q.push_back('{ch: 8'd0, data: 8'hA0});
        s_sts_valid = 1'b1;
        s_sts_data  = 8'hA0;
        @(negedge aclk);
        check("full_pop_blocks", 64'(s_cmd_ready), 64'd0);
        check("full_pop_ready",  64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;
        exp_cmd_q.push_back('{dest: 1'b0, addr: atab[0][2], len: ltab[0][2]});
        @(negedge aclk);
        check("after_pop_outst", 64'(outstanding), 64'd3);
        check("after_pop_ready", 64'(s_cmd_ready), 64'd1);
        step();
        s_cmd_valid = '0;

        // Drain: heads are 1,0,1,0.
        send_sts(8'hB1, 1);
        send_sts(8'hB2, 0);
        send_sts(8'hB3, 1);
        send_sts(8'hB4, 0);
        @(negedge aclk);
        check("drain_outstanding", 64'(outstanding), 64'd0);

        // In-order routing for commands from 1,0,1.
        step();
        issue_cmd(1, 64'h0000_1111_0000_0000, 32'h0000_0100);
        issue_cmd(0, 64'h0000_2222_0000_0000, 32'h0000_0200);
        issue_cmd(1, 64'h0000_3333_0000_0000, 32'h0000_0300);
        @(negedge aclk);
        check("route_outstanding", 64'(outstanding), 64'd3);
        step();
        send_sts(8'h01, 1);
        send_sts(8'h02, 0);
        send_sts(8'h03, 1);
        @(negedge aclk);
        check("route_drained", 64'(outstanding), 64'd0);

        // Memory-side back-pressure holds the output register.
        step();
        m_cmd_ready = 1'b0;
        issue_cmd(0, 64'hDEAD_BEEF_0000_0040, 32'h0000_0040);
        s_cmd_valid = 2'b10;
        s_cmd_address[64 +: 64] = 64'hCAFE_F00D_0000_0080;
        s_cmd_length[32 +: 32]  = 32'h0000_0080;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_valid",   64'(m_cmd_valid),   64'd1);
            check("bp_addr",    m_cmd_address,      64'hDEAD_BEEF_0000_0040);
            check("bp_len",     64'(m_cmd_length),  64'h40);
            check("bp_dest",    64'(m_cmd_dest),    64'd0);
            check("bp_no_ready", 64'(s_cmd_ready),  64'd0);
        end
        step();
        m_cmd_ready = 1'b1;
        exp_cmd_q.push_back('{dest: 1'b1, addr: 64'hCAFE_F00D_0000_0080, len: 32'h0000_0080});
        @(negedge aclk);
        check("bp_release_ready", 64'(s_cmd_ready), 64'd2);
        step();
        s_cmd_valid = '0;

        // Status back-pressure on head channel 0.
        exp_sts_q.push_back('{ch: 8'd0, data: 8'h55});
        m_sts_ready = 2'b10;
        s_sts_valid = 1'b1;
        s_sts_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("sbp_s_sts_ready", 64'(s_sts_ready), 64'd0);
            check("sbp_m_sts_valid", 64'(m_sts_valid), 64'd1);
        end
        step();
        m_sts_ready = 2'b11;
        @(negedge aclk);
        check("sbp_release", 64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;
        send_sts(8'h66, 1);

        // Status with empty tracker waits for the next push.
        s_sts_valid = 1'b1;
        s_sts_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("empty_s_sts_ready", 64'(s_sts_ready), 64'd0);
            check("empty_m_sts_valid", 64'(m_sts_valid), 64'd0);
        end
        exp_sts_q.push_back('{ch: 8'd1, data: 8'h77});
        step();
        issue_cmd(1, 64'h0000_0000_7777_0000, 32'h0000_0007);
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!s_sts_ready && cyc < 5);
        check("empty_late_accept", 64'(s_sts_ready), 64'd1);
        step();
        s_sts_valid = 1'b0;

        // Reset mid-operation: 3 outstanding, one held in the output register.
        issue_cmd(0, 64'h0000_0000_0000_A000, 32'h0000_000A);
        issue_cmd(1, 64'h0000_0000_0000_B000, 32'h0000_000B);
        @(negedge aclk);
        step();
        m_cmd_ready = 1'b0;
        issue_cmd(0, 64'h0000_0000_0000_C000, 32'h0000_000C);
        @(negedge aclk);
        check("pre_rst_outst", 64'(outstanding), 64'd3);
        check("pre_rst_valid", 64'(m_cmd_valid), 64'd1);
        #2;
        s_sts_valid = 1'b1;
        s_cmd_valid = 2'b11;
        s_cmd_address[0 +: 64]  = 64'h0123_4567_89AB_CDEF; s_cmd_length[0 +: 32]  = 32'h0000_0011;
        s_cmd_address[64 +: 64] = 64'hFEDC_BA98_7654_3210; s_cmd_length[32 +: 32] = 32'h0000_0022;
        aresetn = 1'b0;
        #1;
        exp_cmd_q.delete();
        check("arst_m_cmd_valid", 64'(m_cmd_valid),  64'd0);
        check("arst_m_cmd_addr",  m_cmd_address,     64'd0);
        check("arst_m_cmd_dest",  64'(m_cmd_dest),   64'd0);
        check("arst_outstanding", 64'(outstanding),  64'd0);
        check("arst_s_cmd_ready", 64'(s_cmd_ready),  64'd0);
        check("arst_s_sts_ready", 64'(s_sts_ready),  64'd0);
        check("arst_m_sts_valid", 64'(m_sts_valid),  64'd0);
        step();
        step();
        s_sts_valid = 1'b0;
        m_cmd_ready = 1'b1;
        aresetn     = 1'b1;
        exp_cmd_q.push_back('{dest: 1'b0, addr: 64'h0123_4567_89AB_CDEF, len: 32'h0000_0011});
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (s_cmd_ready == '0 && cyc < 5);
        check("post_rst_grant", 64'(s_cmd_ready), 64'd1);
        step();
        s_cmd_valid = '0;
        @(negedge aclk);
        check("post_rst_outst", 64'(outstanding), 64'd1);
        step();

        check("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
        check("sts_q_empty", 64'(exp_sts_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
